// File: rtl/viterbi_pkg.sv
// Shared Viterbi survivor-memory definitions: controller states, bank indices
// and the traceback routing table selected by the delayed write bank.
package viterbi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [1:0] BANK_A = 2'd0;
  localparam logic [1:0] BANK_B = 2'd1;
  localparam logic [1:0] BANK_C = 2'd2;
  localparam logic [1:0] BANK_D = 2'd3;

  typedef struct packed {
    logic [1:0] tbu0_src0;
    logic [1:0] tbu0_src1;
    logic [1:0] tbu1_src0;
    logic [1:0] tbu1_src1;
    logic       tbu0_sel;
    logic       tbu1_sel;
  } route_t;

  // One row per delayed write bank: which banks each traceback unit reads.
  localparam route_t ROUTE_Q2_A = '{tbu0_src0: BANK_D, tbu0_src1: BANK_C,
                                    tbu1_src0: BANK_C, tbu1_src1: BANK_B,
                                    tbu0_sel: 1'b0, tbu1_sel: 1'b1};
  localparam route_t ROUTE_Q2_B = '{tbu0_src0: BANK_D, tbu0_src1: BANK_C,
                                    tbu1_src0: BANK_A, tbu1_src1: BANK_D,
                                    tbu0_sel: 1'b1, tbu1_sel: 1'b0};
  localparam route_t ROUTE_Q2_C = '{tbu0_src0: BANK_B, tbu0_src1: BANK_A,
                                    tbu1_src0: BANK_A, tbu1_src1: BANK_D,
                                    tbu0_sel: 1'b0, tbu1_sel: 1'b1};
  localparam route_t ROUTE_Q2_D = '{tbu0_src0: BANK_B, tbu0_src1: BANK_A,
                                    tbu1_src0: BANK_C, tbu1_src1: BANK_B,
                                    tbu0_sel: 1'b1, tbu1_sel: 1'b0};

  localparam route_t [3:0] ROUTE_TABLE = {ROUTE_Q2_D, ROUTE_Q2_C, ROUTE_Q2_B, ROUTE_Q2_A};

endpackage

// File: rtl/bank_rotator.sv
// Write counter and bank rotation for the four-bank survivor memory; wrap is
// asserted combinationally on the accepted write of the last word of a bank.
module bank_rotator
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] wr_cnt,
  output logic [1:0]    wr_bank,
  output logic          wrap
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] wr_cnt_reg, wr_cnt_next;
  logic [1:0]    wr_bank_reg, wr_bank_next;

  // clear has priority so a restart coinciding with the last word never rotates
  assign wrap = advance && !clear && (wr_cnt_reg == LAST);

  always_comb begin
    wr_cnt_next  = wr_cnt_reg;
    wr_bank_next = wr_bank_reg;
    if (clear) begin
      wr_cnt_next  = '0;
      wr_bank_next = BANK_A;
    end else if (advance) begin
      wr_cnt_next = wr_cnt_reg + 1'b1;
      if (wrap) begin
        wr_bank_next = wr_bank_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_reg  <= '0;
      wr_bank_reg <= BANK_A;
    end else begin
      wr_cnt_reg  <= wr_cnt_next;
      wr_bank_reg <= wr_bank_next;
    end
  end

  assign wr_cnt  = wr_cnt_reg;
  assign wr_bank = wr_bank_reg;

endmodule

// File: rtl/trellis_mem_ctrl.sv
// Survivor-memory controller: writes ACS selection words into a rotating set
// of four banks and steers the other banks to two traceback units.
module trellis_mem_ctrl
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [DW-1:0] sel_in,
  output logic [3:0]    mem_wr,
  output logic [4*AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    wr_bank,
  output logic          block_done,
  output logic          tbu0_en,
  output logic          tbu1_en,
  output logic          tbu0_sel,
  output logic          tbu1_sel,
  output logic [1:0]    tbu0_src0,
  output logic [1:0]    tbu0_src1,
  output logic [1:0]    tbu1_src0,
  output logic [1:0]    tbu1_src1
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t state_reg, state_next;

  logic            accept;
  logic            wrap;
  logic [AW-1:0]   wr_cnt;
  logic [AW-1:0]   rd_cnt;
  logic [3:0]      wr_onehot;
  logic [4*AW-1:0] addr_next;

  logic [3:0]      mem_wr_reg;
  logic [4*AW-1:0] mem_addr_reg;
  logic [DW-1:0]   mem_wdata_reg;
  logic            block_done_reg;
  logic [1:0]      bank_q1_reg, bank_q2_reg;
  logic            tbu0_en_reg, tbu1_en_reg;
  route_t          route_reg;

  // Words arriving while IDLE are dropped; the first accepted word follows the FILL entry.
  assign accept = in_valid && enable && (state_reg != ST_IDLE);

  bank_rotator #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_rotator (
    .clk    (clk),
    .rst    (rst),
    .clear  (!enable),
    .advance(accept),
    .wr_cnt (wr_cnt),
    .wr_bank(wr_bank),
    .wrap   (wrap)
  );

  assign rd_cnt = LAST - wr_cnt;

  // Address by position relative to the write bank: write, read, idle, read.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic [1:0] rel;
    assign rel = 2'(gi) - wr_bank;
    assign addr_next[gi*AW +: AW] = (rel == 2'd0) ? wr_cnt :
                                    (rel == 2'd2) ? '0 : rd_cnt;
    assign wr_onehot[gi] = (wr_bank == 2'(gi));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (enable) state_next = ST_FILL;
      ST_FILL: if (bank_q2_reg == BANK_C) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
    if (!enable) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wr_reg     <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      block_done_reg <= 1'b0;
      bank_q1_reg    <= BANK_A;
      bank_q2_reg    <= BANK_A;
      tbu0_en_reg    <= 1'b0;
      tbu1_en_reg    <= 1'b0;
      route_reg      <= ROUTE_TABLE[BANK_A];
    end else begin
      route_reg <= ROUTE_TABLE[bank_q2_reg];
      if (!enable) begin
        mem_wr_reg     <= '0;
        block_done_reg <= 1'b0;
        bank_q1_reg    <= BANK_A;
        bank_q2_reg    <= BANK_A;
        tbu0_en_reg    <= 1'b0;
        tbu1_en_reg    <= 1'b0;
      end else begin
        bank_q1_reg    <= wr_bank;
        bank_q2_reg    <= bank_q1_reg;
        block_done_reg <= wrap;
        if (accept) begin
          mem_wr_reg    <= wr_onehot;
          mem_addr_reg  <= addr_next;
          mem_wdata_reg <= sel_in;
        end else begin
          mem_wr_reg <= '0;
        end
        // Traceback units come online once their banks hold a full block, then stay on.
        if (state_reg == ST_IDLE) begin
          tbu0_en_reg <= 1'b0;
          tbu1_en_reg <= 1'b0;
        end else begin
          if (bank_q2_reg == BANK_C) tbu0_en_reg <= 1'b1;
          if (bank_q2_reg == BANK_D) tbu1_en_reg <= 1'b1;
        end
      end
    end
  end

  assign mem_wr     = mem_wr_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign block_done = block_done_reg;
  assign tbu0_en    = tbu0_en_reg;
  assign tbu1_en    = tbu1_en_reg;
  assign tbu0_src0  = route_reg.tbu0_src0;
  assign tbu0_src1  = route_reg.tbu0_src1;
  assign tbu1_src0  = route_reg.tbu1_src0;
  assign tbu1_src1  = route_reg.tbu1_src1;
  assign tbu0_sel   = route_reg.tbu0_sel;
  assign tbu1_sel   = route_reg.tbu1_sel;

endmodule

// File: tb/tb_trellis_mem_ctrl.sv
// Scoreboard bench for trellis_mem_ctrl: stimulus queues expected bank writes,
// a negedge monitor pops and compares them whenever a write is presented.
module tb_trellis_mem_ctrl;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 8;

  localparam logic [9:0] ROW0 = {2'd3, 2'd2, 2'd2, 2'd1, 1'b0, 1'b1};
  localparam logic [9:0] ROW1 = {2'd3, 2'd2, 2'd0, 2'd3, 1'b1, 1'b0};
  localparam logic [9:0] ROW2 = {2'd1, 2'd0, 2'd0, 2'd3, 1'b0, 1'b1};
  localparam logic [9:0] ROW3 = {2'd1, 2'd0, 2'd2, 2'd1, 1'b1, 1'b0};

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable = 1'b0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   sel_in = '0;
  logic [3:0]      mem_wr;
  logic [4*AW-1:0] mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [1:0]      wr_bank;
  logic            block_done;
  logic            tbu0_en, tbu1_en, tbu0_sel, tbu1_sel;
  logic [1:0]      tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1;
  logic [9:0]      route_act;

  trellis_mem_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .sel_in(sel_in),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .wr_bank(wr_bank),
    .block_done(block_done), .tbu0_en(tbu0_en), .tbu1_en(tbu1_en),
    .tbu0_sel(tbu0_sel), .tbu1_sel(tbu1_sel),
    .tbu0_src0(tbu0_src0), .tbu0_src1(tbu0_src1),
    .tbu1_src0(tbu1_src0), .tbu1_src1(tbu1_src1)
  );

  assign route_act = {tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1, tbu0_sel, tbu1_sel};

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      wr;
    logic [4*AW-1:0] addr;
    logic [DW-1:0]   wdata;
    logic            done;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   e_cnt = 0;
  int   e_bank = 0;
  bit   e_active = 1'b0;
  int   cyc = 0;
  int   cyc_bank2 = -1, cyc_bank3 = -1, cyc_tbu0 = -1, cyc_tbu1 = -1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Write bank w gets the count, its neighbours the descending read address, the opposite bank 0.
  function automatic logic [4*AW-1:0] exp_addr(input int bank, input int cnt);
    logic [4*AW-1:0] a;
    a = '0;
    a[((bank + 0) % 4)*AW +: AW] = AW'(cnt);
    a[((bank + 1) % 4)*AW +: AW] = AW'(DEPTH - 1 - cnt);
    a[((bank + 3) % 4)*AW +: AW] = AW'(DEPTH - 1 - cnt);
    a[((bank + 2) % 4)*AW +: AW] = '0;
    return a;
  endfunction

  function automatic logic [DW-1:0] pat(input int bank, input int cnt);
    return DW'((cnt * 5 + bank * 61 + 17) & 255);
  endfunction

  task automatic send(input bit v, input bit en);
    exp_t e;
    in_valid = v;
    enable   = en;
    sel_in   = pat(e_bank, e_cnt);
    if (v && en && e_active) begin
      e.wr    = 4'b0001 << e_bank;
      e.addr  = exp_addr(e_bank, e_cnt);
      e.wdata = sel_in;
      e.done  = (e_cnt == DEPTH - 1);
      exp_q.push_back(e);
      if (e_cnt == DEPTH - 1) begin
        e_cnt  = 0;
        e_bank = (e_bank + 1) % 4;
      end else begin
        e_cnt++;
      end
    end
    if (!en) begin
      e_cnt  = 0;
      e_bank = 0;
    end
    e_active = en;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_block_done"}, block_done, 0);
    chk({tag, "_tbu0_en"}, tbu0_en, 0);
    chk({tag, "_tbu1_en"}, tbu1_en, 0);
    chk({tag, "_wr_bank"}, wr_bank, 0);
    chk({tag, "_route"}, route_act, ROW0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (cyc_bank2 < 0 && wr_bank == 2'd2) cyc_bank2 = cyc;
    if (cyc_bank3 < 0 && wr_bank == 2'd3) cyc_bank3 = cyc;
    if (cyc_tbu0 < 0 && tbu0_en) cyc_tbu0 = cyc;
    if (cyc_tbu1 < 0 && tbu1_en) cyc_tbu1 = cyc;
    if (rst) begin
      if (block_done) n_done++;
      if (mem_wr != 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", mem_wr, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_mem_wr", mem_wr, e.wr);
          chk("sb_mem_addr", mem_addr, e.addr);
          chk("sb_mem_wdata", mem_wdata, e.wdata);
          chk("sb_block_done", block_done, e.done);
        end
      end else begin
        chk("idle_block_done", block_done, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_before;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;

    send(1'b0, 1'b1);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      int b, c;
      b = e_bank;
      c = e_cnt;
      send(1'b1, 1'b1);
      if (b == 0 && c == DEPTH - 1) begin
        chk("wrap0_bank", wr_bank, 1);
        chk("wrap0_done", block_done, 1);
      end
      if (b == 1 && c == 5) begin
        chk("b1_c5_addr", mem_addr, {10'd0, 10'd1018, 10'd5, 10'd1018});
        chk("b1_c5_wr", mem_wr, 4'b0010);
        chk("b1_c5_bank", wr_bank, 1);
        chk("route_q2_b", route_act, ROW1);
      end
      if (b == 2 && c == 100) chk("route_q2_c", route_act, ROW2);
    end

    repeat (5) send(1'b0, 1'b1);
    chk("stream_bank", wr_bank, 3);
    chk("stream_done_count", n_done, 3);
    chk("tbu0_en_on", tbu0_en, 1);
    chk("tbu1_en_on", tbu1_en, 1);
    chk("tbu0_delay", cyc_tbu0 - cyc_bank2, 3);
    chk("tbu1_delay", cyc_tbu1 - cyc_bank3, 3);
    chk("route_q2_d", route_act, ROW3);

    repeat (4) send(1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    exp_q.delete();
    e_cnt = 0;
    e_bank = 0;
    e_active = 1'b0;
    in_valid = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    send(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b1);
      chk("toggle_valid_wr", mem_wr, 4'b0001);
      send(1'b0, 1'b1);
      chk("toggle_idle_wr", mem_wr, 4'b0000);
    end

    while (e_cnt != DEPTH - 1) send(1'b1, 1'b1);
    done_before = n_done;
    send(1'b1, 1'b0);
    chk("drop_block_done", block_done, 0);
    chk("drop_wr_bank", wr_bank, 0);
    chk("drop_mem_wr", mem_wr, 0);
    chk("drop_tbu0_en", tbu0_en, 0);
    send(1'b1, 1'b1);
    chk("drop_no_done_pulse", n_done, done_before);
    chk("restart_idle_wr", mem_wr, 0);
    send(1'b1, 1'b1);
    chk("restart_wr", mem_wr, 4'b0001);
    chk("restart_addr_a", mem_addr[AW-1:0], 0);

    send(1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trellis_mem_ctrl.md
TRELLIS_MEM_CTRL -- requirements
Module: trellis_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, which sets the words per trellis bank (a power of two).
REQ-002 SHALL have parameter AW, default 10, equal to log2(DEPTH), which sets the address width.
REQ-003 SHALL have parameter DW, default 8, which sets the selection-word width (one bit per trellis state).
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1 bit: decoder run; low forces a synchronous restart.
REQ-007 SHALL have port in_valid, input, 1 bit: sel_in holds a valid ACS selection word this cycle.
REQ-008 SHALL have port sel_in, input, DW bits: ACS survivor-selection word.
REQ-009 SHALL have port mem_wr, output, 4 bits: one-hot write enable for banks A..D (bit0 = A).
REQ-010 SHALL have port mem_addr, output, 4xAW bits: packed per-bank address, bank A in the LSBs.
REQ-011 SHALL have port mem_wdata, output, DW bits: write data, common to all banks.
REQ-012 SHALL have port wr_bank, output, 2 bits: bank currently being written.
REQ-013 SHALL have port block_done, output, 1 bit: one-cycle pulse when a bank fill completes.
REQ-014 SHALL have ports tbu0_en and tbu1_en, outputs, 1 bit each: traceback unit enables.
REQ-015 SHALL have ports tbu0_sel and tbu1_sel, outputs, 1 bit each: traceback phase select.
REQ-016 SHALL have ports tbu0_src0, tbu0_src1, tbu1_src0 and tbu1_src1, outputs, 2 bits each: bank index routed to each TBU data input.

Function
REQ-017 SHALL keep wr_cnt (AW bits); when in_valid=1 in RUN or FILL it increments, otherwise it holds.
REQ-018 SHALL derive rd_cnt = DEPTH-1-wr_cnt combinationally, so read addresses descend.
REQ-019 SHALL, when wr_cnt=DEPTH-1 with in_valid=1: wrap wr_cnt to 0, advance wr_bank mod 4 (3 wraps to 0), and pulse block_done on the next cycle.
REQ-020 SHALL register all bank outputs one cycle after in_valid; mem_wr[wr_bank]=1, mem_wdata=sel_in.
REQ-021 SHALL drive per-bank addresses relative to w=wr_bank: bank w gets wr_cnt, banks (w+1)%4 and (w+3)%4 get rd_cnt, bank (w+2)%4 gets 0.
REQ-022 SHALL drive mem_wr=0 in any cycle with in_valid=0; addresses then hold their last value.
REQ-023 SHALL keep FSM states IDLE, FILL and RUN, with these transitions:
- IDLE->FILL when enable=1.
- FILL->RUN when the delayed bank (REQ-024) equals 2.
- any state->IDLE when enable=0.
REQ-024 SHALL delay wr_bank through two registers (bank_q1, bank_q2) that advance every cycle.
REQ-025 SHALL map TBU routing by bank_q2, registered, giving {tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1, tbu0_sel, tbu1_sel}:
- 0 -> {3,2,2,1,0,1}
- 1 -> {3,2,0,3,1,0}
- 2 -> {1,0,0,3,0,1}
- 3 -> {1,0,2,1,1,0}
REQ-026 SHALL set tbu0_en sticky-high the cycle after bank_q2==2, and tbu1_en the cycle after bank_q2==3; both clear only in IDLE or reset.
REQ-027 SHALL, on enable deasserting mid-block, clear the next cycle: wr_cnt=0, wr_bank=0, bank_q1/q2=0, mem_wr=0, tbu*_en=0, block_done=0, state IDLE.
REQ-028 SHALL give enable=0 priority when it coincides with a wrap; the bank does not advance and no block_done is issued.

Reset
REQ-029 SHALL, while rst=0, force:
- state=IDLE; wr_cnt, wr_bank, bank_q1 and bank_q2 to 0.
- mem_wr=0, mem_addr=0, mem_wdata=0, block_done=0.
- tbu0_en and tbu1_en to 0.
- TBU routing to the bank_q2=0 row of REQ-025.

Structure
REQ-030 SHALL place the FSM state enum, bank index constants (A=0..D=3) and the REQ-025 routing table in shared package viterbi_pkg.
REQ-031 SHALL implement the bank rotation/counter as one sub-module, bank_rotator (wr_cnt, wr_bank, wrap pulse).

Verification
REQ-032 SHALL cover: reset, then enable=1 with in_valid held 1 for 1024 cycles -> mem_wr=0001 throughout; wrap -> wr_bank=1, one block_done pulse.
REQ-033 SHALL cover: wr_bank=1, wr_cnt=5 -> mem_addr B=5, A=1018, C=1018, D=0; mem_wr=0010.
REQ-034 SHALL cover: continuous stream of 3*1024 words -> tbu0_en rises 3 cycles after wr_bank becomes 2, and tbu1_en rises 3 cycles after wr_bank becomes 3.
REQ-035 SHALL cover: in_valid toggled 1/0 -> wr_cnt advances only on valid cycles; mem_wr=0000 in the cycle following each invalid cycle.
REQ-036 SHALL cover: enable dropped at wr_cnt=1023 with in_valid=1 -> no block_done, wr_bank=0, wr_cnt=0, state IDLE next cycle.
REQ-037 SHALL cover: rst asserted mid-RUN -> all outputs reach their REQ-029 values immediately, without a clock edge.
